// File: rtl/ex_stage.sv
// Execute stage: input pipeline register, ALU, store-lane steering and a
// 32-iteration restoring divider that owns HI/LO and stalls the pipe while busy.
module ex_stage #(
  parameter int unsigned ID_TO_EX_WD  = 150,
  parameter int unsigned EX_TO_MEM_WD = 80,
  parameter int unsigned STALL_WD     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [37:0]             ex_to_id_bus,
  output logic                    ex_is_load,
  output logic                    stallreq_for_ex,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

  logic [ID_TO_EX_WD-1:0] id_ex_q;

  // Input register: bubble when ID stalls but EX moves on, hold when both stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex_q <= '0;
    end else if (stall[2] && !stall[3]) begin
      id_ex_q <= '0;
    end else if (!stall[2]) begin
      id_ex_q <= id_to_ex_bus;
    end
  end

  logic [1:0]  div_op;
  logic [3:0]  alu_op;
  logic [3:0]  ram_readen;
  logic [31:0] pc;
  logic        ram_en;
  logic [3:0]  ram_wen_code;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] rt_data;

  assign div_op       = id_ex_q[149:148];
  assign alu_op       = id_ex_q[147:144];
  assign ram_readen   = id_ex_q[143:140];
  assign pc           = id_ex_q[139:108];
  assign ram_en       = id_ex_q[107];
  assign ram_wen_code = id_ex_q[106:103];
  assign sel_rf_res   = id_ex_q[102];
  assign rf_we        = id_ex_q[101];
  assign rf_waddr     = id_ex_q[100:96];
  assign src1         = id_ex_q[95:64];
  assign src2         = id_ex_q[63:32];
  assign rt_data      = id_ex_q[31:0];

  // Only bits 2 and 3 of the stall vector concern this stage
  logic unused_stall;
  assign unused_stall = ^{stall[STALL_WD-1:4], stall[1:0]};

  div_state_e  state_q;
  logic [4:0]  cnt_q;
  logic [31:0] quo_q, rem_q, dvs_q, hi_q, lo_q;
  logic        quo_neg_q, rem_neg_q;

  logic [4:0]  shamt;
  logic [31:0] alu_res;
  assign shamt = src1[4:0];

  // ALU result, shifts operate on src2 by src1[4:0]
  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'd0:    alu_res = src1 + src2;
      4'd1:    alu_res = src1 - src2;
      4'd2:    alu_res = {31'b0, $signed(src1) < $signed(src2)};
      4'd3:    alu_res = {31'b0, src1 < src2};
      4'd4:    alu_res = src1 & src2;
      4'd5:    alu_res = src1 | src2;
      4'd6:    alu_res = src1 ^ src2;
      4'd7:    alu_res = ~(src1 | src2);
      4'd8:    alu_res = src2 << shamt;
      4'd9:    alu_res = src2 >> shamt;
      4'd10:   alu_res = $signed(src2) >>> shamt;
      4'd11:   alu_res = {src2[15:0], 16'h0};
      4'd12:   alu_res = hi_q;
      4'd13:   alu_res = lo_q;
      4'd14:   alu_res = src1;
      default: alu_res = '0;
    endcase
  end

  logic [1:0]  off;
  logic [3:0]  wen_lane;
  logic [31:0] wdata_lane;
  assign off = alu_res[1:0];

  // Store lane steering; misaligned halfwords are silently dropped
  always_comb begin
    wen_lane   = 4'b0000;
    wdata_lane = rt_data;
    case (ram_wen_code)
      4'b1111: wen_lane = 4'b1111;
      4'b0001: begin
        wen_lane   = 4'b0001 << off;
        wdata_lane = {4{rt_data[7:0]}};
      end
      4'b0011: begin
        wen_lane   = off[0] ? 4'b0000 : (4'b0011 << off);
        wdata_lane = {2{rt_data[15:0]}};
      end
      default: wen_lane = 4'b0000;
    endcase
  end

  assign ex_to_mem_bus = {ram_readen, pc, ram_en, wen_lane, sel_rf_res, rf_we, rf_waddr, alu_res};
  assign ex_to_id_bus    = {rf_we, rf_waddr, alu_res};
  assign ex_is_load      = ram_en && (ram_readen != 4'b0000);
  assign data_sram_en    = ram_en;
  assign data_sram_wen   = wen_lane;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = wdata_lane;

  logic        div_signed, div_start, src1_neg, src2_neg;
  logic [31:0] src1_abs, src2_abs;
  logic [32:0] rem_shift, trial;
  logic [31:0] quo_nxt, rem_nxt, quo_fix, rem_fix;

  assign div_signed      = (div_op == 2'b01);
  assign div_start       = (state_q == StIdle) && ((div_op == 2'b01) || (div_op == 2'b10))
                           && (src2 != 32'h0);
  assign stallreq_for_ex = div_start || (state_q == StBusy);

  assign src1_neg = div_signed && src1[31];
  assign src2_neg = div_signed && src2[31];
  assign src1_abs = src1_neg ? (32'h0 - src1) : src1;
  assign src2_abs = src2_neg ? (32'h0 - src2) : src2;

  // One restoring step: shift the next dividend bit into the partial remainder
  assign rem_shift = {rem_q, quo_q[31]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign rem_nxt   = trial[32] ? rem_shift[31:0] : trial[31:0];
  assign quo_nxt   = {quo_q[30:0], ~trial[32]};
  assign quo_fix   = quo_neg_q ? (32'h0 - quo_q) : quo_q;
  assign rem_fix   = rem_neg_q ? (32'h0 - rem_q) : rem_q;

  // Divider FSM; HI/LO commit only when the divide instruction leaves EX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (div_start) begin
            state_q   <= StBusy;
            quo_q     <= src1_abs;
            rem_q     <= '0;
            dvs_q     <= src2_abs;
            quo_neg_q <= src1_neg ^ src2_neg;
            rem_neg_q <= src1_neg;
            cnt_q     <= '0;
          end
        end
        StBusy: begin
          quo_q <= quo_nxt;
          rem_q <= rem_nxt;
          if (cnt_q == 5'd31) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        StDone: begin
          if (!stall[3]) begin
            state_q <= StIdle;
            lo_q    <= quo_fix;
            hi_q    <= rem_fix;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed table, random ALU/store and
// divide traffic against an arithmetic reference, plus stall/reset corners.
module tb_ex_stage;

  typedef struct packed {
    logic [1:0]  dop;
    logic [3:0]  aop;
    logic [3:0]  readen;
    logic [31:0] pc;
    logic        en;
    logic [3:0]  wen;
    logic        sel;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] rt;
  } instr_t;

  typedef struct {
    string       name;
    logic [3:0]  aop;
    logic [31:0] s1, s2, rt;
    logic        en;
    logic [3:0]  readen;
    logic [3:0]  wcode;
    logic [31:0] exp_res;
    logic [3:0]  exp_wen;
    logic [31:0] exp_wdata;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [149:0] id_to_ex_bus;
  logic [79:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_id_bus;
  logic         ex_is_load, stallreq_for_ex, data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;

  logic         auto_ctl;
  logic [5:0]   stall_man;
  int           n_vec = 0;
  int           n_err = 0;
  logic [31:0]  hi_m, lo_m;
  vec_t         tbl[$];

  always #5 clk = ~clk;

  // Stand-in for the pipeline controller: a stall request freezes stages 0..3
  always_comb stall = auto_ctl ? (stallreq_for_ex ? 6'b001111 : 6'b000000) : stall_man;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_id_bus    (ex_to_id_bus),
    .ex_is_load      (ex_is_load),
    .stallreq_for_ex (stallreq_for_ex),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = a % 32;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return ~(a | b);
      4'd8:    return b << sh;
      4'd9:    return b >> sh;
      4'd10:   return b[31] ? ~((~b) >> sh) : (b >> sh);
      4'd11:   return b * 32'h0001_0000;
      4'd12:   return hi_m;
      4'd13:   return lo_m;
      4'd14:   return a;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void ref_lanes(input logic [3:0] code, input logic [1:0] off,
                                    input logic [31:0] rt, output logic [3:0] wen,
                                    output logic [31:0] wd);
    wen = 4'b0000;
    wd  = rt;
    if (code == 4'b1111) begin
      wen = 4'b1111;
    end else if (code == 4'b0001) begin
      wen[off] = 1'b1;
      wd = {4{rt[7:0]}};
    end else if (code == 4'b0011 && off[0] == 1'b0) begin
      wen[off] = 1'b1;
      wen[off + 2'd1] = 1'b1;
      wd = {2{rt[15:0]}};
    end
  endfunction

  task automatic check_outs(input string tag, input instr_t in, input logic [31:0] exp_res,
                            input logic [3:0] exp_wen, input logic [31:0] exp_wdata);
    logic [79:0] exp_mem;
    exp_mem = {in.readen, in.pc, in.en, exp_wen, in.sel, in.we, in.wa, exp_res};
    check({tag, ".mem_bus"}, ex_to_mem_bus, exp_mem);
    check({tag, ".id_bus"}, 80'(ex_to_id_bus), 80'({in.we, in.wa, exp_res}));
    check({tag, ".sram"}, 80'({data_sram_en, data_sram_wen, data_sram_addr}),
          80'({in.en, exp_wen, exp_res}));
    if (exp_wen != 4'b0000) check({tag, ".wdata"}, 80'(data_sram_wdata), 80'(exp_wdata));
    check({tag, ".is_load"}, 80'(ex_is_load), 80'(in.en && (in.readen != 4'b0000)));
  endtask

  task automatic issue(input instr_t in);
    id_to_ex_bus = in;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string n, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] rt, input logic en,
                         input logic [3:0] rd, input logic [3:0] wc, input logic [31:0] er,
                         input logic [3:0] ew, input logic [31:0] ewd);
    vec_t v;
    v.name = n; v.aop = op; v.s1 = a; v.s2 = b; v.rt = rt; v.en = en; v.readen = rd;
    v.wcode = wc; v.exp_res = er; v.exp_wen = ew; v.exp_wdata = ewd;
    tbl.push_back(v);
  endtask

  // Issues a divide followed by MFLO and MFHI, checking stall length and results
  task automatic run_div(input string tag, input logic [1:0] dop, input logic [31:0] a,
                         input logic [31:0] b);
    instr_t d, mflo, mfhi;
    logic [31:0] q, r;
    logic [79:0] hold_exp;
    longint sa, sb;
    bit active, done;
    int cyc;
    d = '0; d.dop = dop; d.aop = 4'd15; d.pc = 32'h0040_0100; d.s1 = a; d.s2 = b;
    mflo = '0; mflo.aop = 4'd13; mflo.we = 1'b1; mflo.wa = 5'd8; mflo.pc = 32'h0040_0104;
    mfhi = '0; mfhi.aop = 4'd12; mfhi.we = 1'b1; mfhi.wa = 5'd9; mfhi.pc = 32'h0040_0108;
    hold_exp = {4'b0, d.pc, 44'b0};
    active = ((dop == 2'b01) || (dop == 2'b10)) && (b != 32'h0);
    q = lo_m; r = hi_m;
    if (active && dop == 2'b01) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else if (active) begin
      q = a / b;
      r = a % b;
    end
    issue(d);
    id_to_ex_bus = mflo;
    cyc = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (i == 5 && active) check({tag, ".held_during_div"}, ex_to_mem_bus, hold_exp);
      if (stallreq_for_ex) cyc++;
      else done = 1;
    end
    check({tag, ".stall_cycles"}, 80'(cyc), active ? 80'd33 : 80'd0);
    if (active) begin
      lo_m = q;
      hi_m = r;
    end
    @(posedge clk); #1;
    id_to_ex_bus = mfhi;
    @(negedge clk);
    check_outs({tag, ".mflo"}, mflo, lo_m, 4'b0, 32'h0);
    @(posedge clk); #1;
    id_to_ex_bus = '0;
    @(negedge clk);
    check_outs({tag, ".mfhi"}, mfhi, hi_m, 4'b0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t in, a_in, b_in;
    logic [3:0] ew;
    logic [31:0] ewd, er;
    logic [3:0] codes [5];
    codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0011;
    codes[3] = 4'b1111; codes[4] = 4'b0101;
    hi_m = '0; lo_m = '0;
    auto_ctl = 1'b1; stall_man = '0;

    // Reset with live traffic on the input bus: everything must stay zero
    rst = 1'b0;
    in = '0; in.aop = 4'd0; in.s1 = 32'd9; in.s2 = 32'd1; in.we = 1'b1; in.wa = 5'd3;
    in.en = 1'b1; in.readen = 4'b1111; in.pc = 32'h1234_5678;
    id_to_ex_bus = in;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.mem_bus", ex_to_mem_bus, 80'h0);
    check("reset.id_bus", 80'(ex_to_id_bus), 80'h0);
    check("reset.misc", 80'({ex_is_load, stallreq_for_ex, data_sram_en, data_sram_wen}), 80'h0);
    check("reset.sram", 80'({data_sram_addr, data_sram_wdata}), 80'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    add_vec("add",      4'd0,  32'd5,          32'hFFFF_FFFF, 32'h0, 0, 4'h0, 4'h0, 32'd4,          4'h0, 32'h0);
    add_vec("mfhi0",    4'd12, 32'd1,          32'd2,         32'h0, 0, 4'h0, 4'h0, 32'h0,          4'h0, 32'h0);
    add_vec("mflo0",    4'd13, 32'd1,          32'd2,         32'h0, 0, 4'h0, 4'h0, 32'h0,          4'h0, 32'h0);
    add_vec("sub",      4'd1,  32'd3,          32'd5,         32'h0, 0, 4'h0, 4'h0, 32'hFFFF_FFFE,  4'h0, 32'h0);
    add_vec("slt",      4'd2,  32'hFFFF_FFFF,  32'd1,         32'h0, 0, 4'h0, 4'h0, 32'd1,          4'h0, 32'h0);
    add_vec("sltu",     4'd3,  32'hFFFF_FFFF,  32'd1,         32'h0, 0, 4'h0, 4'h0, 32'd0,          4'h0, 32'h0);
    add_vec("and",      4'd4,  32'hF0F0_F0F0,  32'hFF00_FF00, 32'h0, 0, 4'h0, 4'h0, 32'hF000_F000,  4'h0, 32'h0);
    add_vec("or",       4'd5,  32'hF0F0_F0F0,  32'h0F0F_0000, 32'h0, 0, 4'h0, 4'h0, 32'hFFFF_F0F0,  4'h0, 32'h0);
    add_vec("xor",      4'd6,  32'hFFFF_0000,  32'h0F0F_0F0F, 32'h0, 0, 4'h0, 4'h0, 32'hF0F0_0F0F,  4'h0, 32'h0);
    add_vec("nor",      4'd7,  32'h0000_FFFF,  32'h00FF_0000, 32'h0, 0, 4'h0, 4'h0, 32'hFF00_0000,  4'h0, 32'h0);
    add_vec("sll",      4'd8,  32'd4,          32'h0000_1234, 32'h0, 0, 4'h0, 4'h0, 32'h0001_2340,  4'h0, 32'h0);
    add_vec("srl",      4'd9,  32'd8,          32'h8000_0000, 32'h0, 0, 4'h0, 4'h0, 32'h0080_0000,  4'h0, 32'h0);
    add_vec("sra",      4'd10, 32'd8,          32'h8000_0000, 32'h0, 0, 4'h0, 4'h0, 32'hFF80_0000,  4'h0, 32'h0);
    add_vec("lui",      4'd11, 32'h55,         32'h0000_ABCD, 32'h0, 0, 4'h0, 4'h0, 32'hABCD_0000,  4'h0, 32'h0);
    add_vec("pass",     4'd14, 32'hBFC0_0008,  32'h1,         32'h0, 0, 4'h0, 4'h0, 32'hBFC0_0008,  4'h0, 32'h0);
    add_vec("op15",     4'd15, 32'h7,          32'h9,         32'h0, 0, 4'h0, 4'h0, 32'h0,          4'h0, 32'h0);
    add_vec("sb_1003",  4'd0,  32'h1000,       32'd3,  32'h0000_00AB, 1, 4'h0, 4'b0001, 32'h1003, 4'b1000, 32'hABAB_ABAB);
    add_vec("sh_1001",  4'd0,  32'h1000,       32'd1,  32'h1234_5678, 1, 4'h0, 4'b0011, 32'h1001, 4'b0000, 32'h0);
    add_vec("sh_1002",  4'd0,  32'h1000,       32'd2,  32'h1234_BEEF, 1, 4'h0, 4'b0011, 32'h1002, 4'b1100, 32'hBEEF_BEEF);
    add_vec("sw_1004",  4'd0,  32'h1000,       32'd4,  32'hDEAD_BEEF, 1, 4'h0, 4'b1111, 32'h1004, 4'b1111, 32'hDEAD_BEEF);
    add_vec("sb_1001",  4'd0,  32'h1000,       32'd1,  32'h0000_0012, 1, 4'h0, 4'b0001, 32'h1001, 4'b0010, 32'h1212_1212);
    add_vec("badcode",  4'd0,  32'h1000,       32'd0,  32'h0000_0012, 1, 4'h0, 4'b0111, 32'h1000, 4'b0000, 32'h0);
    add_vec("lw",       4'd0,  32'h2000,       32'd8,  32'h0, 1, 4'b1111, 4'h0, 32'h2008, 4'b0000, 32'h0);
    add_vec("rd_no_en", 4'd0,  32'h2000,       32'd8,  32'h0, 0, 4'b0001, 4'h0, 32'h2008, 4'b0000, 32'h0);

    foreach (tbl[i]) begin
      in = '0;
      in.aop = tbl[i].aop; in.s1 = tbl[i].s1; in.s2 = tbl[i].s2; in.rt = tbl[i].rt;
      in.en = tbl[i].en; in.readen = tbl[i].readen; in.wen = tbl[i].wcode;
      in.pc = 32'h0040_0000 + 32'(i * 4); in.wa = 5'(i + 1); in.we = 1'b1; in.sel = i[0];
      issue(in);
      @(negedge clk);
      check_outs(tbl[i].name, in, tbl[i].exp_res, tbl[i].exp_wen, tbl[i].exp_wdata);
    end

    // Divider corner cases
    run_div("div_m7_2", 2'b01, 32'hFFFF_FFF9, 32'd2);
    run_div("divu_big", 2'b10, 32'hFFFF_FFFF, 32'h10);
    run_div("div_by_0", 2'b01, 32'h1234_5678, 32'h0);
    run_div("divu_by_0", 2'b10, 32'h1, 32'h0);
    run_div("div_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("div_none", 2'b11, 32'd100, 32'd7);

    // Downstream stall holds the register, ID-only stall inserts a bubble
    auto_ctl = 1'b0; stall_man = 6'b000000;
    a_in = '0; a_in.aop = 4'd0; a_in.s1 = 32'h100; a_in.s2 = 32'h23; a_in.we = 1'b1;
    a_in.wa = 5'd4; a_in.pc = 32'h0040_0200;
    b_in = '0; b_in.aop = 4'd5; b_in.s1 = 32'hA0; b_in.s2 = 32'h0B; b_in.we = 1'b1;
    b_in.wa = 5'd5; b_in.pc = 32'h0040_0204;
    issue(a_in);
    @(negedge clk);
    check_outs("hold.before", a_in, 32'h123, 4'b0, 32'h0);
    id_to_ex_bus = b_in; stall_man = 6'b001111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_outs("hold.held", a_in, 32'h123, 4'b0, 32'h0);
    stall_man = 6'b000111;
    @(posedge clk); #1;
    @(negedge clk);
    check("bubble.mem_bus", ex_to_mem_bus, 80'h0);
    check("bubble.id_bus", 80'(ex_to_id_bus), 80'h0);
    stall_man = 6'b000000;
    @(posedge clk); #1;
    @(negedge clk);
    check_outs("bubble.after", b_in, 32'hAB, 4'b0, 32'h0);
    auto_ctl = 1'b1;

    // Random ALU and store traffic
    for (int k = 0; k < 40; k++) begin
      in = '0;
      in.aop = 4'($urandom_range(0, 15));
      in.s1 = $urandom; in.s2 = (k % 3 == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      in.rt = $urandom; in.pc = $urandom; in.wa = 5'($urandom); in.we = 1'($urandom);
      in.sel = 1'($urandom); in.en = 1'($urandom); in.readen = 4'($urandom);
      in.wen = codes[$urandom_range(0, 4)];
      er = ref_alu(in.aop, in.s1, in.s2);
      ref_lanes(in.wen, er[1:0], in.rt, ew, ewd);
      issue(in);
      @(negedge clk);
      check_outs($sformatf("rand%0d", k), in, er, ew, ewd);
    end

    // Random divides
    for (int k = 0; k < 8; k++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (k == 3) ? 32'h0 : (k % 3 == 0) ? 32'($urandom_range(1, 1000))
         : (k % 3 == 1) ? (32'h0 - 32'($urandom_range(1, 50))) : $urandom;
      run_div($sformatf("rdiv%0d", k), 2'($urandom_range(1, 2)), ra, rb);
    end

    // Establish nonzero HI/LO, then reset in the middle of a divide
    run_div("pre_reset", 2'b01, 32'd100, 32'd7);
    in = '0; in.dop = 2'b01; in.aop = 4'd15; in.s1 = 32'd1000; in.s2 = 32'd3;
    issue(in);
    repeat (10) @(posedge clk);
    #2;
    check("midreset.busy", 80'(stallreq_for_ex), 80'd1);
    rst = 1'b0;
    #1;
    check("midreset.stallreq", 80'(stallreq_for_ex), 80'd0);
    check("midreset.mem_bus", ex_to_mem_bus, 80'h0);
    hi_m = '0; lo_m = '0;
    id_to_ex_bus = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    in = '0; in.aop = 4'd13; in.we = 1'b1; in.wa = 5'd6;
    issue(in);
    @(negedge clk);
    check_outs("midreset.mflo", in, lo_m, 4'b0, 32'h0);
    in.aop = 4'd12;
    issue(in);
    @(negedge clk);
    check_outs("midreset.mfhi", in, hi_m, 4'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS-style pipeline. Sits between ID and MEM.
- Registers id_to_ex_bus and performs the ALU operation.
- Runs a 32-iteration signed/unsigned divider that owns the HI/LO registers, and stalls the pipeline while the divider is busy.
- Issues the data-SRAM request and produces ex_to_mem_bus, plus a forwarding bus back to ID.

Parameters:
- ID_TO_EX_WD, 150, width of id_to_ex_bus.
- EX_TO_MEM_WD, 80, width of ex_to_mem_bus.
- STALL_WD, 6, width of the stall bus.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  STALL_WD  pipeline stall vector; 1 = Stop.
- id_to_ex_bus  in  150  field layout:
  - div_op[149:148]: 00 none, 01 div, 10 divu, 11 none.
  - alu_op[147:144]
  - data_ram_readen[143:140]
  - pc[139:108]
  - data_ram_en[107]
  - data_ram_wen[106:103]: size code.
  - sel_rf_res[102]
  - rf_we[101]
  - rf_waddr[100:96]
  - src1[95:64]
  - src2[63:32]
  - rt_data[31:0]
- ex_to_mem_bus  out  80  field layout:
  - data_ram_readen[79:76]
  - pc[75:44]
  - data_ram_en[43]
  - data_ram_wen[42:39]: lane-shifted.
  - sel_rf_res[38]
  - rf_we[37]
  - rf_waddr[36:32]
  - ex_result[31:0]
- ex_to_id_bus  out  38  {rf_we, rf_waddr, ex_result}, for forwarding.
- ex_is_load  out  1  data_ram_en && readen!=0, for the load-use stall in ID.
- stallreq_for_ex  out  1  divider stall request.
- data_sram_en  out  1  equals data_ram_en.
- data_sram_wen  out  4  lane-shifted byte write enable.
- data_sram_addr  out  32  equals ex_result.
- data_sram_wdata  out  32  lane-replicated store data.

Behaviour:
- Input register, evaluated in priority order:
  - rst low: cleared (async).
  - stall[2]=Stop && stall[3]=NoStop: load all-zero bubble.
  - stall[2]=NoStop: load id_to_ex_bus.
  - otherwise: hold.
- Reset:
  - Input register, HI, LO, divider state all zero; FSM to IDLE.
  - Consequently every output is 0.
- ALU (combinational from the input register), by alu_op:
  - 0 ADD, 1 SUB: wrap, no overflow trap.
  - 2 SLT, 3 SLTU: result 1/0.
  - 4 AND, 5 OR, 6 XOR, 7 NOR.
  - 8 SLL, 9 SRL, 10 SRA: src2 shifted by src1[4:0].
  - 11 LUI: src2<<16.
  - 12 MFHI = HI, 13 MFLO = LO.
  - 14 PASS = src1 (link address).
  - 15 = 0.
- Store lanes, with off = ex_result[1:0]:
  - wen code 1111 (word): wen 1111, wdata = rt_data.
  - wen code 0001 (byte): wen 0001<<off, wdata = {4{rt_data[7:0]}}.
  - wen code 0011 (half): off 0 or 2 gives wen 0011<<off, wdata = {2{rt_data[15:0]}}; off 1 or 3 gives wen 0000 (store dropped, no exception).
  - Any other code: wen 0000.
- Loads: ex_result is the address. readen passes through unchanged; MEM does the extraction.
- Divider FSM: IDLE, BUSY, DONE.
  - IDLE → BUSY when div_op is div or divu and src2 != 0. On that edge: latch |src1| and |src2| (divu: raw values), signs, and cnt = 0.
  - BUSY: one restoring shift-subtract iteration per cycle. On the edge with cnt==31, go to DONE; otherwise cnt+1.
  - DONE: apply signs. Quotient is negated if the operand signs differ. Remainder takes the dividend's sign.
  - DONE → IDLE, writing LO = quotient and HI = remainder, on the first edge with stall[3]=NoStop.
  - stallreq_for_ex = (IDLE && div_op valid && src2!=0) || BUSY.
  - Timing: a div entering EX in cycle 0 holds stallreq high for cycles 0–32. DONE is in cycle 33, where stallreq=0; HI/LO update at the end of cycle 33.
- Divide by zero: no stall, no FSM activity, HI/LO unchanged.
- 0x80000000 / -1 (signed): quotient 0x80000000, remainder 0.
- MFHI/MFLO immediately after a div sees the new HI/LO, because they are written before the next instruction reaches EX.
- Reset asserted mid-division: FSM returns to IDLE, stallreq drops immediately, HI/LO = 0.
- While the stage is held by downstream stalls, outputs and SRAM requests repeat unchanged. Repeated identical stores are acceptable.

Test Plan:
- Reset release, then ADD src1=5, src2=0xFFFFFFFF → ex_result=4, rf fields passed through; all outputs were 0 during reset.
- SB at address 0x1003 with rt_data=0x000000AB → data_sram_wen=1000, wdata=0xABABABAB; SH at 0x1001 → wen=0000.
- div src1=-7, src2=2 → stallreq high for exactly 33 cycles; the following MFLO returns 0xFFFFFFFD and MFHI returns 0xFFFFFFFF.
- divu 0xFFFFFFFF / 0x10 → LO=0x0FFFFFFF, HI=0xF; div by 0 → stallreq never asserts, HI/LO unchanged.
- Drive stall=001111 while EX is busy → EX register holds and MEM gets a bubble; stall=000111 → ex_to_mem_bus zero on the next edge; rst low at BUSY cycle 10 → stallreq=0 immediately and HI/LO=0.
